// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: data widths, the
// fetch-state encoding, the fetch queue entry layout and small helpers.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int QDEPTH  = 2;
    localparam int QCNT_W  = 2;

    localparam logic [XLEN-1:0]    PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0000;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect, status and decode-side
// handshake signals. master = fetch unit, slave = its environment.
interface instr_fetch_unit_if;
    import riscv_pkg::*;

    logic               fetch_en;
    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;
    logic               halted;
    logic               misalign_err;

    modport master (
        input  fetch_en, imem_rdata, redirect, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, halted, misalign_err
    );

    modport slave (
        output fetch_en, imem_rdata, redirect, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, halted, misalign_err
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry {pc, instr} FIFO built as a head register plus one tail
// register, so the head feeds decode straight from flops and keeps its
// last contents when the queue drains.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  fq_entry_t         push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [QCNT_W-1:0] count,
    output logic              head_valid,
    output fq_entry_t         head
);

    fq_entry_t         head_r;
    fq_entry_t         tail_r;
    logic [QCNT_W-1:0] count_r;
    fq_entry_t         head_nxt_s;
    fq_entry_t         tail_nxt_s;
    logic [QCNT_W-1:0] count_nxt_s;

    // Next-state of the head/tail registers and occupancy count.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        head_nxt_s  = push_data;
                        count_nxt_s = 2'd1;
                    end else begin
                        count_nxt_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_nxt_s = push_data;
                    end else if (push) begin
                        tail_nxt_s  = push_data;
                        count_nxt_s = 2'd2;
                    end else if (pop) begin
                        count_nxt_s = 2'd0;
                    end else begin
                        count_nxt_s = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_nxt_s = tail_r;
                        if (push) begin
                            tail_nxt_s = push_data;
                        end else begin
                            count_nxt_s = 2'd1;
                        end
                    end else begin
                        count_nxt_s = 2'd2;
                    end
                end
                default: begin
                    count_nxt_s = 2'd0;
                end
            endcase
        end
    end

    // Queue storage and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '{pc: 32'd0, instr: NOP};
            tail_r  <= '{pc: 32'd0, instr: NOP};
            count_r <= 2'd0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != 2'd0);
    assign head       = head_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues one word per cycle into a 2-entry
// queue toward decode, applies execute redirects and stops at PC_LIMIT.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_LIMIT = 32'd256
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   pc_nxt_s;
    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic              misalign_r;
    logic              misalign_nxt_s;
    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   redirect_tgt_s;
    logic              fire_s;
    logic              deq_s;
    logic [QCNT_W-1:0] q_count_s;
    logic              q_valid_s;
    fq_entry_t         q_head_s;
    fq_entry_t         q_push_s;

    assign pc_plus4_s     = pc_r + PC_STEP;
    assign redirect_tgt_s = align_word(bus.redirect_pc);
    assign deq_s          = q_valid_s & bus.out_ready;
    // Full queue may still accept a word when decode frees the head this cycle.
    assign fire_s         = (state_r == FS_RUN) & bus.fetch_en & ~bus.redirect &
                            ((q_count_s < 2'd2) | deq_s);
    assign q_push_s       = '{pc: pc_r, instr: bus.imem_rdata};

    // PC, fetch state and misalignment flag next-state; redirect wins over fetch.
    always_comb begin
        pc_nxt_s       = pc_r;
        state_nxt_s    = state_r;
        misalign_nxt_s = 1'b0;
        if (bus.redirect) begin
            pc_nxt_s       = redirect_tgt_s;
            state_nxt_s    = (redirect_tgt_s >= PC_LIMIT) ? FS_HALT : FS_RUN;
            misalign_nxt_s = (bus.redirect_pc[1:0] != 2'b00);
        end else if (fire_s) begin
            pc_nxt_s    = pc_plus4_s;
            state_nxt_s = (pc_plus4_s >= PC_LIMIT) ? FS_HALT : state_r;
        end else begin
            pc_nxt_s    = pc_r;
            state_nxt_s = state_r;
        end
    end

    // PC, state and error-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            state_r    <= FS_RUN;
            misalign_r <= 1'b0;
        end else begin
            pc_r       <= pc_nxt_s;
            state_r    <= state_nxt_s;
            misalign_r <= misalign_nxt_s;
        end
    end

    fetch_queue u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (fire_s),
        .push_data  (q_push_s),
        .pop        (deq_s),
        .flush      (bus.redirect),
        .count      (q_count_s),
        .head_valid (q_valid_s),
        .head       (q_head_s)
    );

    assign bus.imem_addr    = pc_r;
    assign bus.out_valid    = q_valid_s;
    assign bus.out_instr    = q_head_s.instr;
    assign bus.out_pc       = q_head_s.pc;
    assign bus.halted       = (state_r == FS_HALT);
    assign bus.misalign_err = misalign_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes the hand-computed
// delivery order into a scoreboard, a monitor checks every accepted word.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [31:0] imem [0:63];

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_LIMIT (32'd256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: combinational read, zero past program memory.
    assign bus.imem_rdata = (bus.imem_addr < 32'd256) ? imem[bus.imem_addr[7:2]] : 32'h0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = imem[pc[7:2]];
        exp_q.push_back(e);
    endtask

    // Monitor: every word accepted by decode must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delivery: got pc %h instr %h, none expected",
                         bus.out_pc, bus.out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                    errors++;
                    $display("FAIL delivery: got pc %h instr %h expected pc %h instr %h",
                             bus.out_pc, bus.out_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        bit done;
        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;
        imem[1]  = 32'h019806B3;
        imem[11] = 32'h00948663;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.fetch_en    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);

        // Streaming with decode always ready: 0,4,8,12 back to back.
        reset = 1'b0; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        push_exp(32'd0); push_exp(32'd4); push_exp(32'd8); push_exp(32'd12);
        chk("c0_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("c1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("c1_imem_addr", bus.imem_addr, 32'd4);
        tick();
        chk("c2_imem_addr", bus.imem_addr, 32'd8);
        chk("c2_misalign", {31'd0, bus.misalign_err}, 32'd0);
        tick(); tick(); tick();
        reset = 1'b1; bus.out_ready = 1'b0;
        tick();
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_imem_addr", bus.imem_addr, 32'd0);

        // Backpressure from the first valid cycle: queue fills, pc holds at 8.
        tick();
        reset = 1'b0;
        tick();
        chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_out_pc", bus.out_pc, 32'd0);
        tick();
        chk("bp_imem_addr_a", bus.imem_addr, 32'd8);
        tick();
        chk("bp_imem_addr_b", bus.imem_addr, 32'd8);
        chk("bp_head_pc", bus.out_pc, 32'd0);
        chk("bp_head_instr", bus.out_instr, imem[0]);
        bus.out_ready = 1'b1;
        push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
        tick(); tick(); tick();

        // Redirect to 44 with two entries queued.
        bus.out_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'd44;
        chk("pre_redir_imem_addr", bus.imem_addr, 32'd20);
        tick();
        bus.redirect = 1'b0;
        chk("redir_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("redir_imem_addr", bus.imem_addr, 32'd44);
        chk("redir_misalign", {31'd0, bus.misalign_err}, 32'd0);
        tick();
        chk("redir_out_pc", bus.out_pc, 32'd44);
        chk("redir_out_instr", bus.out_instr, 32'h00948663);
        bus.out_ready = 1'b1;
        push_exp(32'd44); push_exp(32'd48);
        tick();

        // Misaligned redirect target 46 -> aligned to 44 with an error pulse.
        bus.redirect = 1'b1; bus.redirect_pc = 32'd46;
        tick();
        bus.redirect = 1'b0;
        chk("mis_pulse", {31'd0, bus.misalign_err}, 32'd1);
        chk("mis_imem_addr", bus.imem_addr, 32'd44);
        chk("mis_out_valid", {31'd0, bus.out_valid}, 32'd0);
        for (int p = 44; p <= 252; p += 4) push_exp(p);
        tick();
        chk("mis_pulse_end", {31'd0, bus.misalign_err}, 32'd0);

        // Free run to the end of program memory.
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.halted && !bus.out_valid) done = 1'b1;
            else tick();
        end
        chk("halt_reached", {31'd0, bus.halted}, 32'd1);
        chk("halt_imem_addr", bus.imem_addr, 32'd256);
        repeat (3) tick();
        chk("halt_imem_stable", bus.imem_addr, 32'd256);
        chk("halt_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("halt_held", {31'd0, bus.halted}, 32'd1);
        chk("halt_drained", exp_q.size(), 32'd0);

        // Redirect out of HALT back to 0.
        bus.redirect = 1'b1; bus.redirect_pc = 32'd0;
        tick();
        bus.redirect = 1'b0;
        chk("unhalt_halted", {31'd0, bus.halted}, 32'd0);
        chk("unhalt_imem_addr", bus.imem_addr, 32'd0);
        push_exp(32'd0); push_exp(32'd4);
        tick(); tick(); tick();
        bus.out_ready = 1'b0;
        tick();
        chk("full_imem_addr", bus.imem_addr, 32'd16);
        chk("full_out_pc", bus.out_pc, 32'd8);

        // Reset together with a redirect while the queue is full.
        reset = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'd46;
        tick();
        chk("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst2_imem_addr", bus.imem_addr, 32'd0);
        chk("rst2_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst2_misalign", {31'd0, bus.misalign_err}, 32'd0);
        reset = 1'b0; bus.redirect = 1'b0;
        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the single-cycle RISC-V core.
- Owns the program counter and drives the byte address into the instruction memory.
- Captures each returned 32-bit word, with its PC, into a 2-entry fetch queue that feeds decode through a valid/ready handshake.
- Applies branch/jump redirects from execute, and halts fetch when the PC reaches the end of program memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_LIMIT, 32'd256, first byte address past program memory (64 words x 4); fetch halts when pc >= PC_LIMIT.
- QDEPTH, 2, fetch queue entries; fixed at 2, so the count is 2 bits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- fetch_en  in  1  when 0, no new fetch is issued; queue and outputs hold.
- imem_addr  out  32  byte address to instruction memory; always equal to pc.
- imem_rdata  in  32  instruction word, combinational from imem_addr in the same cycle.
- redirect  in  1  branch taken or jump from execute.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  PC of the head instruction.
- halted  out  1  fetch stopped at PC_LIMIT.
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset (synchronous, highest priority):
  - pc=RESET_PC, count=0, queue pointers=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, misalign_err=0.
- States:
  - RUN: fetching.
  - HALT: pc >= PC_LIMIT, no fetch.
  - RUN->HALT when the next pc >= PC_LIMIT. HALT->RUN only on redirect. fetch_en=0 does not change state.
- Dequeue: deq = out_valid & out_ready.
- Fetch condition: fire = (state==RUN) & fetch_en & ~redirect & (count<2 | deq).
- On fire:
  - Push {pc, imem_rdata} at the tail.
  - pc <= pc+4, 32-bit wrap.
  - If pc+4 >= PC_LIMIT, state <= HALT.
- Count: count <= count + fire - deq. Simultaneous push and pop with count=2 is legal and keeps count=2.
- Redirect has priority over fetch and dequeue:
  - Flush the queue: count=0, out_valid=0 next cycle. A dequeue in the same cycle still counts as accepted by decode.
  - pc <= {redirect_pc[31:2], 2'b00}; state <= RUN, or HALT if the aligned target >= PC_LIMIT.
  - misalign_err <= (redirect_pc[1:0] != 0) for exactly one cycle; otherwise 0.
- Latency and throughput:
  - A word fetched at cycle n appears at out_* at cycle n+1 (registered queue head).
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
  - First out_valid occurs in the 2nd cycle after reset deasserts.
- Queue full (count=2) with out_ready=0: no fetch, pc holds, imem_addr stable, head stable.
- Head stability: out_instr and out_pc must not change while out_valid=1 & out_ready=0, unless a redirect occurs.
- Empty queue: out_valid=0; out_instr and out_pc hold their last values (don't-care to decode).
- halted = (state==HALT). The queue still drains in HALT.
- Reset mid-operation: all in-flight queue entries are discarded the same edge.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32, INSTR_W=32, PC_STEP=4, NOP=32'h0000_0000.
  - Fetch state enum {FS_RUN, FS_HALT}.
- One sub-module: fetch_queue, a 2-entry FIFO of {pc,instr} with push, pop, flush, count, head outputs.
- The PC/state logic stays in the top module.

Test Plan:
- Reset, then fetch_en=1, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles; out_instr at pc 4 = 32'h019806B3; misalign_err stays 0.
- out_ready=0 from the cycle out_pc=0 -> count reaches 2, imem_addr holds at 8, head holds pc 0. Release out_ready -> pcs 0,4,8 delivered back-to-back with no gap.
- Redirect with redirect_pc=44 while 2 entries are queued -> next cycle out_valid=0; following cycle out_pc=44, out_instr=32'h00948663.
- Redirect with redirect_pc=46 -> misalign_err=1 for one cycle, imem_addr=44.
- Free-run to PC_LIMIT=256 -> last delivered out_pc=252, halted=1, imem_addr=256 stable. Then redirect_pc=0 -> halted=0, out_pc=0 follows.
- Reset asserted while count=2 and redirect=1 -> next cycle out_valid=0, imem_addr=0, halted=0, misalign_err=0.
